// File: rtl/approx_mul_trunc_pipe_pkg.sv
// Shared types and power-up defaults for the approximate truncating multiplier.
package approx_mul_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_COMP  = 2'd2
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  localparam mode_e DEFAULT_MODE = MODE_TRUNC;

  // Encoding 3 is reserved and behaves exactly like plain truncation.
  function automatic mode_e normMode(input logic [1:0] raw);
    case (raw)
      2'd0:    return MODE_EXACT;
      2'd2:    return MODE_COMP;
      default: return MODE_TRUNC;
    endcase
  endfunction

endpackage

// File: rtl/approx_mul_trunc_pipe_if.sv
// Stream and configuration handshakes of the approximate multiplier.
interface approx_mul_trunc_pipe_if #(
  parameter int WIDTH = 16,
  parameter int KW    = $clog2(WIDTH + 1)
) ();

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [1:0]           cfg_mode;
  logic [KW-1:0]        cfg_trunc;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_z;
  logic [1:0]           out_mode;
  logic                 busy;
  logic [31:0]          op_count;

  modport master (
    output cfg_valid, cfg_mode, cfg_trunc, in_valid, in_a, in_b, out_ready,
    input  cfg_ready, in_ready, out_valid, out_z, out_mode, busy, op_count
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_trunc, in_valid, in_a, in_b, out_ready,
    output cfg_ready, in_ready, out_valid, out_z, out_mode, busy, op_count
  );

endinterface

// File: rtl/approx_mul_trunc_pipe_mask.sv
// Combinational operand transform: clear the low k bits, optionally re-inserting
// the half-LSB so the truncated value sits at the midpoint of the dropped range.
module approx_operand_mask
  import approx_mul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TRUNC_MAX = 10,
  parameter int KW        = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_x,
  input  mode_e            i_mode,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_y
);

  // k never exceeds TRUNC_MAX, so only the bits below it need any logic.
  always_comb begin
    o_y = i_x;
    if (i_mode != MODE_EXACT) begin
      for (int i = 0; i < TRUNC_MAX; i++) begin
        if (KW'(i) < i_k) o_y[i] = 1'b0;
        if ((i_mode == MODE_COMP) && (KW'(i + 1) == i_k)) o_y[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/approx_mul_trunc_pipe.sv
// Pipelined unsigned approximate multiplier with runtime truncation depth and a
// drain-then-apply configuration FSM so reconfiguration never touches in-flight data.
module approx_mul_trunc_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TRUNC_MAX = 10,
  parameter int STAGES    = 2,
  parameter int KW        = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    rst,
  approx_mul_trunc_pipe_if.slave bus
);

  localparam int PW   = 2 * WIDTH;
  localparam int LAST = STAGES - 1;

  state_e            r_state;
  state_e            w_nextState;
  mode_e             r_cfgMode;
  logic [KW-1:0]     r_cfgK;
  logic [STAGES-1:0] r_vld;
  mode_e             r_mode [STAGES];
  logic [31:0]       r_opCount;

  logic              w_stall;
  logic              w_en;
  logic              w_busy;
  logic              w_inReady;
  logic              w_cfgReady;
  logic              w_accept;
  logic [KW-1:0]     w_cfgK;
  logic [WIDTH-1:0]  w_maskA;
  logic [WIDTH-1:0]  w_maskB;
  logic [PW-1:0]     w_outZ;

  // A stalled output freezes the whole pipe; bubbles are not squeezed out.
  assign w_stall  = r_vld[LAST] && !bus.out_ready;
  assign w_en     = !w_stall;
  assign w_busy   = |r_vld;
  assign w_accept = bus.in_valid && w_inReady;
  assign w_cfgK   = (bus.cfg_trunc > KW'(TRUNC_MAX)) ? KW'(TRUNC_MAX) : bus.cfg_trunc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_cfgMode <= DEFAULT_MODE;
      r_cfgK    <= KW'(TRUNC_MAX);
    end else begin
      r_state <= w_nextState;
      if (w_cfgReady) begin
        r_cfgMode <= normMode(bus.cfg_mode);
        r_cfgK    <= w_cfgK;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_cfgReady  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_inReady = w_en;
        if (bus.cfg_valid) w_nextState = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!w_busy) begin
          w_cfgReady  = 1'b1;
          w_nextState = ST_RUN;
        end
      end
      default: w_nextState = ST_RUN;
    endcase
  end

  approx_operand_mask #(.WIDTH(WIDTH), .TRUNC_MAX(TRUNC_MAX), .KW(KW)) u_maskA (
    .i_x    (bus.in_a),
    .i_mode (r_cfgMode),
    .i_k    (r_cfgK),
    .o_y    (w_maskA)
  );

  approx_operand_mask #(.WIDTH(WIDTH), .TRUNC_MAX(TRUNC_MAX), .KW(KW)) u_maskB (
    .i_x    (bus.in_b),
    .i_mode (r_cfgMode),
    .i_k    (r_cfgK),
    .o_y    (w_maskB)
  );

  // Mode tags travel with their data; payload registers only load behind a valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int s = 0; s < STAGES; s++) r_mode[s] <= DEFAULT_MODE;
    end else if (w_en) begin
      r_vld[0] <= w_accept;
      if (w_accept) r_mode[0] <= r_cfgMode;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) r_mode[s] <= r_mode[s-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      logic [PW-1:0] r_z;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_z <= '0;
        end else if (w_en && w_accept) begin
          r_z <= PW'(w_maskA) * PW'(w_maskB);
        end
      end

      assign w_outZ = r_z;
    end else begin : g_multi
      logic [WIDTH-1:0] r_opA;
      logic [WIDTH-1:0] r_opB;
      logic [PW-1:0]    r_z [STAGES-1];

      // Stage 1 holds masked operands; entry s-1 of r_z holds the product of stage s+1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_opA <= '0;
          r_opB <= '0;
          for (int s = 0; s < STAGES - 1; s++) r_z[s] <= '0;
        end else if (w_en) begin
          if (w_accept) begin
            r_opA <= w_maskA;
            r_opB <= w_maskB;
          end
          if (r_vld[0]) r_z[0] <= PW'(r_opA) * PW'(r_opB);
          for (int s = 1; s < STAGES - 1; s++) begin
            if (r_vld[s]) r_z[s] <= r_z[s-1];
          end
        end
      end

      assign w_outZ = r_z[STAGES-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opCount <= '0;
    end else if (r_vld[LAST] && bus.out_ready) begin
      r_opCount <= r_opCount + 32'd1;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.cfg_ready = w_cfgReady;
  assign bus.out_valid = r_vld[LAST];
  assign bus.out_z     = w_outZ;
  assign bus.out_mode  = r_mode[LAST];
  assign bus.busy      = w_busy;
  assign bus.op_count  = r_opCount;

endmodule

// File: tb/tb_approx_mul_trunc_pipe.sv
// Bench for approx_mul_trunc_pipe: literal cases pin the reference model, then
// randomized traffic with backpressure and reconfiguration is scored against it.
module tb_approx_mul_trunc_pipe;

  localparam int WIDTH     = 16;
  localparam int TRUNC_MAX = 10;
  localparam int STAGES    = 2;
  localparam int KW        = $clog2(WIDTH + 1);
  localparam int PW        = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst;

  int nChecks   = 0;
  int nPass     = 0;
  int cfgPulses = 0;

  // Reference model state: active config plus a queue of expected results.
  int            mdlMode  = 1;
  int            mdlK     = TRUNC_MAX;
  int            mdlCount = 0;
  logic [PW-1:0] qZ [$];
  int            qMode [$];

  bit            prevStall = 1'b0;
  logic [PW-1:0] prevZ;
  logic [1:0]    prevMode;

  approx_mul_trunc_pipe_if #(.WIDTH(WIDTH), .KW(KW)) bus ();

  approx_mul_trunc_pipe #(
    .WIDTH(WIDTH), .TRUNC_MAX(TRUNC_MAX), .STAGES(STAGES), .KW(KW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic noteTimeout(input string name);
    nChecks++;
    $display("[TB] FAIL %s: timed out, got no handshake, expected one within bound at %0t", name, $time);
  endtask

  function automatic logic [WIDTH-1:0] refOperand(input logic [WIDTH-1:0] x, input int mode, input int k);
    logic [WIDTH-1:0] y;
    if (mode == 0) return x;
    y = (x >> k) << k;
    if (mode == 2 && k > 0) y = y | (WIDTH'(1) << (k - 1));
    return y;
  endfunction

  function automatic logic [PW-1:0] refProduct(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input int mode, input int k);
    return PW'(refOperand(a, mode, k)) * PW'(refOperand(b, mode, k));
  endfunction

  function automatic logic [WIDTH-1:0] randOperand();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // Compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    logic [PW-1:0] z;
    int            m;
    if (rst) begin
      qZ.delete();
      qMode.delete();
      mdlMode   = 1;
      mdlK      = TRUNC_MAX;
      mdlCount  = 0;
      prevStall = 1'b0;
    end else begin
      checkOutput("busy", 64'(bus.busy), 64'(qZ.size() != 0));
      checkOutput("op_count", 64'(bus.op_count), 64'(mdlCount));
      if (prevStall) begin
        checkOutput("hold_valid", 64'(bus.out_valid), 64'(1));
        checkOutput("hold_z", 64'(bus.out_z), 64'(prevZ));
        checkOutput("hold_mode", 64'(bus.out_mode), 64'(prevMode));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (qZ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL out_extra: got out_z 0x%0h, expected no output at %0t", bus.out_z, $time);
        end else begin
          z = qZ.pop_front();
          m = qMode.pop_front();
          checkOutput("out_z", 64'(bus.out_z), 64'(z));
          checkOutput("out_mode", 64'(bus.out_mode), 64'(m));
          mdlCount++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        qZ.push_back(refProduct(bus.in_a, bus.in_b, mdlMode, mdlK));
        qMode.push_back(mdlMode);
      end
      if (bus.cfg_ready) begin
        cfgPulses++;
        mdlMode = (int'(bus.cfg_mode) == 3) ? 1 : int'(bus.cfg_mode);
        mdlK    = (int'(bus.cfg_trunc) > TRUNC_MAX) ? TRUNC_MAX : int'(bus.cfg_trunc);
      end
      prevStall = bus.out_valid && !bus.out_ready;
      prevZ     = bus.out_z;
      prevMode  = bus.out_mode;
    end
  end

  // Leaves in_valid high after the accepting edge; the caller decides what follows.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit acc = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) noteTimeout("accept");
  endtask

  task automatic waitOut(output logic [PW-1:0] z, output logic [1:0] m, output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      #1;
      n++;
    end
    z = bus.out_z;
    m = bus.out_mode;
    if (n >= 50) noteTimeout("out_valid");
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyConfig(input logic [1:0] mode, input logic [KW-1:0] trunc, output int n);
    bit got = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = mode;
    bus.cfg_trunc = trunc;
    n = 0;
    while (n < 50 && !got) begin
      @(negedge clk);
      got = bus.cfg_ready;
      if (!got) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!got) noteTimeout("cfg_ready");
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
  endtask

  task automatic runCase(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [PW-1:0] expZ, input logic [1:0] expMode);
    logic [PW-1:0] z;
    logic [1:0]    m;
    int            n;
    applyStimulus(a, b);
    bus.in_valid = 1'b0;
    waitOut(z, m, n);
    checkOutput({name, "_z"}, 64'(z), 64'(expZ));
    checkOutput({name, "_mode"}, 64'(m), 64'(expMode));
    checkOutput({name, "_latency"}, 64'(n + 1), 64'(STAGES));
  endtask

  task automatic doReset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int pulsesBefore;
    bit inOk;
    bit cfgOk;

    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = '0;
    bus.cfg_trunc = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("rst_cfg_ready", 64'(bus.cfg_ready), 64'(0));
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_out_z", 64'(bus.out_z), 64'(0));
    checkOutput("rst_out_mode", 64'(bus.out_mode), 64'(1));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_op_count", 64'(bus.op_count), 64'(0));
    @(posedge clk);
    #1;

    // Literal cases: 0xFC00^2, (0x18*0x28), exact, clamped k, reserved mode, k=0 compensate.
    runCase("default", 16'hFFFF, 16'hFFFF, 32'hF810_0000, 2'd1);
    applyConfig(2'd2, KW'(4), n);
    checkOutput("cfg_latency_empty", 64'(n), 64'(1));
    runCase("comp_k4", 16'h0013, 16'h0021, 32'h0000_03C0, 2'd2);
    applyConfig(2'd0, KW'(0), n);
    runCase("exact", 16'h1234, 16'h0010, 32'h0001_2340, 2'd0);
    applyConfig(2'd1, KW'(15), n);
    runCase("clamp_k15", 16'hFFFF, 16'h0FFF, 32'h0BD0_0000, 2'd1);
    applyConfig(2'd3, KW'(4), n);
    runCase("mode3", 16'h00FF, 16'h00FF, 32'h0000_E100, 2'd1);
    applyConfig(2'd2, KW'(0), n);
    runCase("comp_k0", 16'h1234, 16'h0003, 32'h0000_369C, 2'd2);

    // Backpressure: four operands against a stalled output.
    doReset();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(randOperand(), randOperand());
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        checkOutput("bp_accepted", 64'(qZ.size()), 64'(2));
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && mdlCount < 4; i++) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_op_count", 64'(bus.op_count), 64'(4));
    checkOutput("bp_drained", 64'(qZ.size()), 64'(0));

    // Reconfiguration requested with two items in flight.
    doReset();
    pulsesBefore = cfgPulses;
    applyStimulus(16'h8001, 16'h0C07);
    bus.in_a = 16'hFFFF;
    bus.in_b = 16'h0403;
    fork
      applyConfig(2'd0, KW'(0), n);
      begin
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("drain_in_ready", 64'(bus.in_ready), 64'(0));
      end
    join
    checkOutput("cfg_latency_busy", 64'(n), 64'(STAGES + 1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("cfg_single_pulse", 64'(cfgPulses - pulsesBefore), 64'(1));
    runCase("post_cfg_exact", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 2'd0);

    // Reset while draining drops the pending request and restores the default config.
    doReset();
    bus.out_ready = 1'b0;
    applyStimulus(16'h1357, 16'h2468);
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = 2'd0;
    bus.cfg_trunc = '0;
    pulsesBefore  = cfgPulses;
    repeat (3) @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("mid_rst_cfg_ready", 64'(bus.cfg_ready), 64'(0));
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_rst_no_pulse", 64'(cfgPulses - pulsesBefore), 64'(0));
    runCase("mid_rst_default", 16'hFFFF, 16'hFFFF, 32'hF810_0000, 2'd1);

    // Randomized traffic with random backpressure and occasional reconfiguration.
    doReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      inOk  = bus.in_ready;
      cfgOk = bus.cfg_ready;
      @(posedge clk);
      #1;
      if (!bus.in_valid || inOk) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.in_a     = randOperand();
        bus.in_b     = randOperand();
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (bus.cfg_valid && cfgOk) begin
        bus.cfg_valid = 1'b0;
      end else if (!bus.cfg_valid && $urandom_range(0, 39) == 0) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_mode  = 2'($urandom_range(0, 3));
        bus.cfg_trunc = KW'($urandom_range(0, 31));
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && (qZ.size() != 0 || bus.cfg_valid); i++) begin
      @(negedge clk);
      cfgOk = bus.cfg_ready;
      @(posedge clk);
      #1;
      if (cfgOk) bus.cfg_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("rand_drained", 64'(qZ.size()), 64'(0));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
